data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 57 +++++
 rtl/data_mem_responder_if.sv | 40 ++++
 rtl/load_extend.sv | 36 +++
 rtl/data_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg -- shared types and constants for data_mem_responder.
//   state_t      : responder FSM states
//   dlen_t       : store size codes (data_length)
//   F3_*         : load type codes (funct3)
//   BE_*         : SRAM byte-lane enable patterns
//   store_be     : byte enables for a store of a given size and byte offset
//   store_wdata  : store data replicated onto every lane the size can hit
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      WR      = 2'b10,
      RESP    = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      DL_WORD = 2'b00,
      DL_HALF = 2'b01,
      DL_BYTE = 2'b10,
      DL_INV  = 2'b11
   } dlen_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   function automatic logic [3:0] store_be(input dlen_t dlen, input logic [1:0] off);
      logic [3:0] be;
      case (dlen)
         DL_WORD: be = BE_WORD;
         DL_HALF: be = off[1] ? BE_HALF_HI : BE_HALF_LO;
         DL_BYTE: be = BE_BYTE0 << off;
         default: be = BE_NONE;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_wdata(input dlen_t dlen, input logic [31:0] d);
      logic [31:0] w;
      case (dlen)
         DL_BYTE: w = {4{d[7:0]}};
         DL_HALF: w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if -- request/response and SRAM bus of data_mem_responder.
//   Request : mem_rd_en, mem_wr_en, addr, wdata, data_length, funct3
//   Response: busy, rdata, rvalid, wdone, misalign
//   SRAM    : sram_cs, sram_we, sram_be, sram_addr, sram_wdata (to SRAM),
//             sram_rdata (from SRAM)
//   modport slave  : the responder
//   modport master : the requester together with the SRAM it talks to
interface data_mem_responder_if #(
   parameter int ADDR_W = 32
);
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [1:0]        data_length;
   logic [2:0]        funct3;
   logic              busy;
   logic [31:0]       rdata;
   logic              rvalid;
   logic              wdone;
   logic              misalign;
   logic              sram_cs;
   logic              sram_we;
   logic [3:0]        sram_be;
   logic [ADDR_W-3:0] sram_addr;
   logic [31:0]       sram_wdata;
   logic [31:0]       sram_rdata;

   modport slave (
      input  mem_rd_en, mem_wr_en, addr, wdata, data_length, funct3, sram_rdata,
      output busy, rdata, rvalid, wdone, misalign,
             sram_cs, sram_we, sram_be, sram_addr, sram_wdata
   );

   modport master (
      output mem_rd_en, mem_wr_en, addr, wdata, data_length, funct3, sram_rdata,
      input  busy, rdata, rvalid, wdone, misalign,
             sram_cs, sram_we, sram_be, sram_addr, sram_wdata
   );
endinterface

// File: rtl/load_extend.sv
// load_extend -- picks the addressed lane out of an SRAM word and extends it.
//   word   : raw 32-bit SRAM read data
//   offset : byte offset of the load (addr[1:0])
//   funct3 : load type; LB/LH sign-extend, LBU/LHU zero-fill,
//            LW and undefined codes return the whole word
//   result : extended load value
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {{24{1'b0}}, byte_sel};
         F3_LHU:  result = {{16{1'b0}}, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder -- turns single-cycle load/store pulses into SRAM cycles.
//   clk : clock, all state on rising edge
//   rst : asynchronous, active-low reset
//   bus : data_mem_responder_if.slave (request, response and SRAM signals)
// Parameters: ADDR_W byte-address width, WAIT_CYC SRAM read latency (1..7).
// Build option: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no SRAM cycle, one-cycle misalign pulse instead of rvalid/wdone).
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int WAIT_CYC = 1
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-3:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   dlen_t             dlen_q, dlen_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       ext_result;

   logic              busy, rvalid, wdone, cs, we;
   logic [3:0]        be;
   logic [ADDR_W-3:0] sram_addr;
   dlen_t             req_dlen;

   assign req_dlen = dlen_t'(bus.data_length);

`ifdef MISALIGN_TRAP_EN
   logic mis_q, mis_d, misalign, ld_mis, st_mis;

   assign ld_mis = ((bus.funct3 == F3_LH || bus.funct3 == F3_LHU) && bus.addr[0])
                || (bus.funct3 == F3_LW && bus.addr[1:0] != 2'b00);
   assign st_mis = (req_dlen == DL_HALF && bus.addr[0])
                || (req_dlen == DL_WORD && bus.addr[1:0] != 2'b00);
`endif

   load_extend u_load_extend (
      .word   (bus.sram_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .result (ext_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         dlen_q  <= DL_WORD;
         rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         dlen_q  <= dlen_d;
         rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      off_d     = off_q;
      f3_d      = f3_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      dlen_d    = dlen_q;
      rdata_d   = rdata_q;
`ifdef MISALIGN_TRAP_EN
      mis_d     = mis_q;
      misalign  = 1'b0;
`endif
      busy      = 1'b1;
      rvalid    = 1'b0;
      wdone     = 1'b0;
      cs        = 1'b0;
      we        = 1'b0;
      be        = BE_NONE;
      sram_addr = waddr_q;

      case (state_q)
         IDLE: begin
            busy      = 1'b0;
            sram_addr = bus.addr[ADDR_W-1:2];
            // Gating with rst keeps the combinational read select low while
            // reset is held, even if a request is being driven.
            if (rst && bus.mem_wr_en) begin
               waddr_d = bus.addr[ADDR_W-1:2];
               off_d   = bus.addr[1:0];
               wdata_d = bus.wdata;
               dlen_d  = req_dlen;
`ifdef MISALIGN_TRAP_EN
               mis_d   = st_mis;
               state_d = st_mis ? RESP : WR;
`else
               state_d = WR;
`endif
            end else if (rst && bus.mem_rd_en) begin
               off_d = bus.addr[1:0];
               f3_d  = bus.funct3;
               cnt_d = 3'(WAIT_CYC - 1);
`ifdef MISALIGN_TRAP_EN
               mis_d = ld_mis;
               if (ld_mis) begin
                  state_d = RESP;
               end else begin
                  cs      = 1'b1;
                  be      = BE_WORD;
                  state_d = RD_WAIT;
               end
`else
               cs      = 1'b1;
               be      = BE_WORD;
               state_d = RD_WAIT;
`endif
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               rdata_d = ext_result;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         WR: begin
            cs      = 1'b1;
            we      = 1'b1;
            be      = store_be(dlen_q, off_q);
            wdone   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            // RESP doubles as the trap-report cycle when a misaligned access
            // was accepted, so no extra state is needed for it.
`ifdef MISALIGN_TRAP_EN
            if (mis_q) misalign = 1'b1;
            else       rvalid   = 1'b1;
`else
            rvalid = 1'b1;
`endif
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy       = busy;
   assign bus.rdata      = rdata_q;
   assign bus.rvalid     = rvalid;
   assign bus.wdone      = wdone;
   assign bus.sram_cs    = cs;
   assign bus.sram_we    = we;
   assign bus.sram_be    = be;
   assign bus.sram_addr  = sram_addr;
   assign bus.sram_wdata = store_wdata(dlen_q, wdata_q);
`ifdef MISALIGN_TRAP_EN
   assign bus.misalign   = misalign;
`else
   assign bus.misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder -- self-checking bench for data_mem_responder.
// A byte-addressed reference memory predicts every load; a latency-accurate
// SRAM model answers the DUT and returns noise whenever no read is due.
module tb_data_mem_responder;

   localparam int WAIT_CYC = 3;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   data_mem_responder_if #(.ADDR_W(32)) bus ();

   data_mem_responder #(.ADDR_W(32), .WAIT_CYC(WAIT_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM model ----------------
   bit   [31:0] sram_mem [64];
   bit   [31:0] pipe_d   [8];
   bit          pipe_v   [8];
   logic [31:0] junk;

   always @(posedge clk) begin
      if (bus.sram_cs && bus.sram_we) begin
         for (int i = 0; i < 4; i++)
            if (bus.sram_be[i]) sram_mem[bus.sram_addr[5:0]][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      end
      pipe_d[0] <= sram_mem[bus.sram_addr[5:0]];
      pipe_v[0] <= bus.sram_cs && !bus.sram_we;
      for (int k = 1; k < 8; k++) begin
         pipe_d[k] <= pipe_d[k-1];
         pipe_v[k] <= pipe_v[k-1];
      end
      junk <= $urandom;
   end

   assign bus.sram_rdata = pipe_v[WAIT_CYC-1] ? pipe_d[WAIT_CYC-1] : junk;

   // ---------------- reference model ----------------
   bit   [7:0]  ref_mem [256];
   logic [31:0] exp_rdata;

   function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
      int v;
      int b;
      case (f3)
         3'b000, 3'b100: begin
            v = int'(ref_mem[a]);
            if (f3 == 3'b000 && v >= 128) v = v - 256;
         end
         3'b001, 3'b101: begin
            b = a - a % 2;
            v = int'(ref_mem[b]) + 256 * int'(ref_mem[b+1]);
            if (f3 == 3'b001 && v >= 32768) v = v - 65536;
         end
         default: begin
            b = a - a % 4;
            return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
         end
      endcase
      return 32'(v);
   endfunction

   task automatic ref_store(input int a, input logic [31:0] d, input logic [1:0] dl);
      int b;
      case (dl)
         2'b10: ref_mem[a] = d[7:0];
         2'b01: begin
            b = a - a % 2;
            ref_mem[b]   = d[7:0];
            ref_mem[b+1] = d[15:8];
         end
         2'b00: begin
            b = a - a % 4;
            for (int i = 0; i < 4; i++) ref_mem[b+i] = 8'(d >> (8*i));
         end
         default: ;
      endcase
   endtask

   function automatic logic [3:0] exp_be(input int a, input logic [1:0] dl);
      case (dl)
         2'b10:   return 4'(1 << (a % 4));
         2'b01:   return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
         2'b00:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] dl);
      case (dl)
         2'b10:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction tasks ----------------
   task automatic do_store(input int a, input logic [31:0] d, input logic [1:0] dl, input string nm);
`ifdef MISALIGN_TRAP_EN
      bit mis;
      mis = (dl == 2'b01 && a % 2 != 0) || (dl == 2'b00 && a % 4 != 0);
`endif
      bus.addr = 32'(a); bus.wdata = d; bus.data_length = dl;
      bus.mem_wr_en = 1'b1; bus.mem_rd_en = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_accept got=%b exp=0", nm, bus.busy); end
      checks++; if (bus.sram_cs !== 1'b0) begin failures++; $display("FAIL %s cs_at_accept got=%b exp=0", nm, bus.sram_cs); end
      step();
      bus.mem_wr_en = 1'b0;
      #1;
`ifdef MISALIGN_TRAP_EN
      if (mis) begin
         checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL %s misalign got=%b exp=1", nm, bus.misalign); end
         checks++; if ({bus.sram_cs, bus.wdone} !== 2'b00) begin failures++; $display("FAIL %s trap_cs_wdone got=%b exp=00", nm, {bus.sram_cs, bus.wdone}); end
         step();
         checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL %s misalign_len got=%b exp=0", nm, bus.misalign); end
      end else
`endif
      begin
         checks++; if ({bus.wdone, bus.sram_cs, bus.sram_we, bus.busy} !== 4'b1111) begin failures++; $display("FAIL %s wr_cycle wdone/cs/we/busy got=%b exp=1111", nm, {bus.wdone, bus.sram_cs, bus.sram_we, bus.busy}); end
         checks++; if (bus.sram_be !== exp_be(a, dl)) begin failures++; $display("FAIL %s sram_be got=%b exp=%b", nm, bus.sram_be, exp_be(a, dl)); end
         checks++; if (bus.sram_addr !== 30'(a / 4)) begin failures++; $display("FAIL %s sram_addr got=%h exp=%h", nm, bus.sram_addr, 30'(a / 4)); end
         if (dl != 2'b11) begin
            checks++; if (bus.sram_wdata !== exp_wdata(d, dl)) begin failures++; $display("FAIL %s sram_wdata got=%h exp=%h", nm, bus.sram_wdata, exp_wdata(d, dl)); end
         end
         step();
         checks++; if ({bus.wdone, bus.sram_cs, bus.busy} !== 3'b000) begin failures++; $display("FAIL %s after_wr wdone/cs/busy got=%b exp=000", nm, {bus.wdone, bus.sram_cs, bus.busy}); end
         ref_store(a, d, dl);
      end
   endtask

   task automatic do_load(input int a, input logic [2:0] f3, input string nm);
      logic [31:0] exp_v;
      int n;
`ifdef MISALIGN_TRAP_EN
      bit mis;
      mis = ((f3 == 3'b001 || f3 == 3'b101) && a % 2 != 0) || (f3 == 3'b010 && a % 4 != 0);
`endif
      exp_v = ref_load(a, f3);
      bus.addr = 32'(a); bus.funct3 = f3;
      bus.mem_rd_en = 1'b1; bus.mem_wr_en = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_accept got=%b exp=0", nm, bus.busy); end
`ifdef MISALIGN_TRAP_EN
      if (mis) begin
         checks++; if (bus.sram_cs !== 1'b0) begin failures++; $display("FAIL %s trap_cs got=%b exp=0", nm, bus.sram_cs); end
         step();
         bus.mem_rd_en = 1'b0;
         #1;
         checks++; if ({bus.misalign, bus.sram_cs, bus.rvalid} !== 3'b100) begin failures++; $display("FAIL %s trap misalign/cs/rvalid got=%b exp=100", nm, {bus.misalign, bus.sram_cs, bus.rvalid}); end
         step();
         checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL %s misalign_len got=%b exp=0", nm, bus.misalign); end
         checks++; if (bus.rdata !== exp_rdata) begin failures++; $display("FAIL %s rdata_kept got=%h exp=%h", nm, bus.rdata, exp_rdata); end
      end else
`endif
      begin
         checks++; if ({bus.sram_cs, bus.sram_we, bus.sram_be} !== 6'b101111) begin failures++; $display("FAIL %s rd_select cs/we/be got=%b exp=101111", nm, {bus.sram_cs, bus.sram_we, bus.sram_be}); end
         checks++; if (bus.sram_addr !== 30'(a / 4)) begin failures++; $display("FAIL %s sram_addr got=%h exp=%h", nm, bus.sram_addr, 30'(a / 4)); end
         step();
         bus.mem_rd_en = 1'b0;
         #1;
         n = 1;
         while (bus.rvalid !== 1'b1 && n < 20) begin
            checks++; if ({bus.sram_cs, bus.busy} !== 2'b01) begin failures++; $display("FAIL %s wait cs/busy got=%b exp=01", nm, {bus.sram_cs, bus.busy}); end
            step();
            n++;
         end
         checks++; if (n != WAIT_CYC + 1) begin failures++; $display("FAIL %s rvalid_latency got=%0d exp=%0d", nm, n, WAIT_CYC + 1); end
         checks++; if (bus.rdata !== exp_v) begin failures++; $display("FAIL %s rdata got=%h exp=%h", nm, bus.rdata, exp_v); end
         exp_rdata = exp_v;
         step();
         checks++; if ({bus.rvalid, bus.busy} !== 2'b00) begin failures++; $display("FAIL %s after_resp rvalid/busy got=%b exp=00", nm, {bus.rvalid, bus.busy}); end
         checks++; if (bus.rdata !== exp_rdata) begin failures++; $display("FAIL %s rdata_hold got=%h exp=%h", nm, bus.rdata, exp_rdata); end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      bus.mem_rd_en = 1'b1;
      #1;
      checks++; if ({bus.busy, bus.rvalid, bus.wdone, bus.misalign, bus.sram_cs, bus.sram_we, bus.sram_be} !== 10'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.busy, bus.rvalid, bus.wdone, bus.misalign, bus.sram_cs, bus.sram_we, bus.sram_be}); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
      step();
      step();
      checks++; if ({bus.busy, bus.sram_cs, bus.rvalid} !== 3'b000) begin failures++; $display("FAIL reset_held busy/cs/rvalid got=%b exp=000", {bus.busy, bus.sram_cs, bus.rvalid}); end
      bus.mem_rd_en = 1'b0;
      rst = 1'b1;
      exp_rdata = '0;
      step();
   endtask

   task automatic test_word();
      do_store(32'h10, 32'hDEADBEEF, 2'b00, "sw");
      do_load(32'h10, 3'b010, "lw");
      checks++; if (bus.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_const got=%h exp=deadbeef", bus.rdata); end
   endtask

   task automatic test_byte();
      do_store(32'h13, 32'h00000080, 2'b10, "sb");
      do_load(32'h13, 3'b000, "lb");
      checks++; if (bus.rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_const got=%h exp=ffffff80", bus.rdata); end
      do_load(32'h13, 3'b100, "lbu");
      checks++; if (bus.rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_const got=%h exp=00000080", bus.rdata); end
   endtask

   task automatic test_half();
      do_store(32'h22, 32'h00008001, 2'b01, "sh");
      do_load(32'h22, 3'b001, "lh");
      checks++; if (bus.rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_const got=%h exp=ffff8001", bus.rdata); end
      do_load(32'h22, 3'b101, "lhu");
      checks++; if (bus.rdata !== 32'h00008001) begin failures++; $display("FAIL lhu_const got=%h exp=00008001", bus.rdata); end
   endtask

   task automatic test_invalid_len();
      do_store(32'h30, 32'h11223344, 2'b00, "sw30");
      do_store(32'h30, 32'hAABBCCDD, 2'b11, "s_inv");
      do_load(32'h30, 3'b010, "lw30");
      checks++; if (bus.rdata !== 32'h11223344) begin failures++; $display("FAIL inv_len_nowrite got=%h exp=11223344", bus.rdata); end
   endtask

   task automatic test_collision();
      int bad;
      bus.addr = 32'h50; bus.wdata = 32'h0BADF00D; bus.data_length = 2'b00; bus.funct3 = 3'b010;
      bus.mem_wr_en = 1'b1; bus.mem_rd_en = 1'b1;
      step();
      // request again while busy in WR: must be ignored
      bus.addr = 32'h54; bus.wdata = 32'h12345678;
      #1;
      checks++; if ({bus.wdone, bus.sram_we, bus.busy} !== 3'b111) begin failures++; $display("FAIL coll_store wdone/we/busy got=%b exp=111", {bus.wdone, bus.sram_we, bus.busy}); end
      step();
      bus.mem_wr_en = 1'b0; bus.mem_rd_en = 1'b0;
      ref_store(32'h50, 32'h0BADF00D, 2'b00);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.wdone !== 1'b0 || bus.rvalid !== 1'b0 || bus.sram_cs !== 1'b0) bad++;
         step();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL coll_extra_pulse got=%0d cycles exp=0", bad); end
      do_load(32'h50, 3'b010, "coll_lw50");
      checks++; if (bus.rdata !== 32'h0BADF00D) begin failures++; $display("FAIL coll_store_data got=%h exp=0badf00d", bus.rdata); end
      do_load(32'h54, 3'b010, "coll_lw54");
   endtask

   task automatic test_misalign();
      do_store(32'h10, 32'h12345678, 2'b00, "ma_sw");
      do_load(32'h11, 3'b010, "ma_lw11");
`ifndef MISALIGN_TRAP_EN
      checks++; if (bus.rdata !== 32'h12345678) begin failures++; $display("FAIL ma_word_aligned got=%h exp=12345678", bus.rdata); end
`endif
      do_load(32'h13, 3'b101, "ma_lhu13");
      do_store(32'h21, 32'h0000CAFE, 2'b01, "ma_sh21");
      do_load(32'h20, 3'b010, "ma_lw20");
   endtask

   task automatic test_reset_mid_read();
      int bad;
      do_store(32'h40, 32'hCAFEF00D, 2'b00, "rr_sw");
      do_load(32'h40, 3'b010, "rr_lw");
      bus.addr = 32'h40; bus.funct3 = 3'b000; bus.mem_rd_en = 1'b1;
      step();
      bus.mem_rd_en = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rr_in_wait busy got=%b exp=1", bus.busy); end
      #2 rst = 1'b0;
      #1;
      exp_rdata = '0;
      checks++; if ({bus.busy, bus.rvalid, bus.wdone, bus.misalign, bus.sram_cs, bus.sram_we, bus.sram_be} !== 10'b0) begin failures++; $display("FAIL rr_ctrl got=%b exp=0", {bus.busy, bus.rvalid, bus.wdone, bus.misalign, bus.sram_cs, bus.sram_we, bus.sram_be}); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rr_rdata got=%h exp=0", bus.rdata); end
      step();
      step();
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.rvalid !== 1'b0 || bus.wdone !== 1'b0 || bus.busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rr_no_pulse got=%0d cycles exp=0", bad); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL rr_rdata_after got=%h exp=0", bus.rdata); end
   endtask

   task automatic test_random();
      int a;
      for (int i = 0; i < 80; i++) begin
         a = int'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0)
            do_store(a, $urandom, 2'($urandom_range(0, 3)), "rnd_st");
         else
            do_load(a, 3'($urandom_range(0, 7)), "rnd_ld");
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      checks = 0;
      failures = 0;
      exp_rdata = '0;
      bus.mem_rd_en = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.data_length = '0;
      bus.funct3 = '0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_invalid_len();
      test_collision();
      test_misalign();
      test_reset_mid_read();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
